pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
- Parametrised, handshaked pipeline-stage register for the ARM core pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generalises the fixed-field ID/EX register: the payload is one packed vector, split into a control field and a data field.
- Adds valid/ready flow control, an optional second (skid) entry so upstream ready is fully registered, and flush with bubble insertion.
- Counts squashed instructions for debug.

Parameters:
- CTRL_W, 8: control-bit width (wb_en, mem_r, mem_w, branch, S, ...). Forced to 0 in every bubble.
- DATA_W, 160: data-field width (PC, Val_Rn, Val_Rm, shift operand, imm24, dest, status).
- SKID, 1: 1 = two-entry skid buffer, in_ready registered; 0 = single entry, in_ready = !m_valid || out_ready (combinational).
- CNT_W, 16: width of the flush-drop counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  squash all held entries and any beat accepted this cycle.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- out_valid  out  1  main entry M valid.
- out_ready  in  1  downstream accepts M this cycle.
- out_ctrl  out  CTRL_W  M control; all-zero whenever out_valid=0.
- out_data  out  DATA_W  M data.
- occupancy  out  2  m_valid + s_valid (0..2; max 1 when SKID=0).
- drop_count  out  CNT_W  saturating count of squashed entries.

Behaviour:
- Definitions: accept = in_valid & in_ready; pop = out_valid & out_ready. M = main entry, S = skid entry.
- Reset (rst=1 at a clock edge): m_valid=s_valid=0, out_ctrl=0, out_data=0, S contents=0, occupancy=0, drop_count=0.
- After reset, in_ready=1 in both modes. rst overrides flush and all handshakes.
- in_ready, SKID=1: equals !s_valid, taken directly from a register.
- in_ready, SKID=0: equals !m_valid || out_ready.
- Invariant: s_valid implies m_valid.
- Latency: an accepted beat appears on out_* on the next cycle when M is empty or popping; there is no combinational in->out path.
- Next-state priority when neither rst nor flush is asserted:
  - M empty or pop, S valid: M <= S, S empties. in_ready was 0, so there is no accept.
  - M empty or pop, S empty, accept: M <= in.
  - M empty or pop, S empty, no accept: m_valid <= 0, out_ctrl <= 0, out_data holds its last value.
  - M full, no pop, accept (SKID=1 only): S <= in, s_valid <= 1.
  - M full, no pop, no accept: hold.
- Ordering: beats leave strictly in acceptance order. No beat is duplicated or lost without flush.
- Flush (rst=0, flush=1):
  - Next cycle: m_valid=s_valid=0 and out_ctrl=0. out_data and S contents are zeroed.
  - A beat accepted in the same cycle is discarded.
  - A pop in the same cycle still completes: downstream owns that beat, and it is not counted.
  - in_ready still follows its normal equation during the flush cycle.
- drop_count: adds (m_valid & !pop) + s_valid + accept, computed during the flush cycle. Range 0..2. Saturates at all-ones and never wraps.
- Flush while empty with no accept: no state change apart from zeroing; drop_count is unchanged.
- out_ctrl is never nonzero while out_valid=0, so a bubble is a NOP downstream.

Test Plan:
1. Reset, then stream beats data=0x1..0x8 with in_valid=1 and out_ready=1 every cycle. Required: each beat appears exactly 1 cycle after acceptance, throughput 1/cycle, occupancy=1, in_ready=1 throughout.
2. SKID=1. Push A=0xA then B=0xB with out_ready=0. Required: occupancy=2, in_ready=0, out_data=0xA. Then raise out_ready. Required: A then B on consecutive cycles, in_ready=1 in the cycle after A pops.
3. Occupancy=2 and out_ready=0, assert flush one cycle. Required: next cycle out_valid=0, out_ctrl=0, occupancy=0, drop_count=2. Second flush with the stage empty: drop_count stays 2.
4. Occupancy=1, in_valid=1, out_ready=1, flush=1 in the same cycle. Required: M pops downstream, the incoming beat is dropped, drop_count +1, next cycle out_valid=0.
5. rst and flush both asserted with occupancy=2. Required: drop_count=0 and all outputs zero next cycle.
6. SKID=0, out_ready=0, M full. Required: in_ready=0. Raise out_ready with in_valid=1. Required: in_ready=1 in the same cycle and the new beat replaces M with no bubble. Preload drop_count near all-ones and flush: drop_count saturates at 0xFFFF.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg
//   Handshaked pipeline-stage register with an optional skid entry and flush.
//   The payload is split into a control field, which is forced to zero in every
//   bubble, and a data field. Squashed entries are counted in a saturating
//   debug counter.
//
// Parameters
//   CTRL_W  control-field width
//   DATA_W  data-field width
//   SKID    1: two entries (main M + skid S), in_ready registered
//           0: single entry, in_ready = !m_valid || out_ready
//   CNT_W   width of drop_count
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               squash held entries and any beat accepted this cycle
//   in_valid/in_ready   upstream handshake
//   in_ctrl/in_data     upstream payload
//   out_valid/out_ready downstream handshake on the main entry M
//   out_ctrl/out_data   M payload (out_ctrl is zero whenever out_valid is 0)
//   occupancy           m_valid + s_valid
//   drop_count          saturating count of squashed entries
module pipe_stage_skid_reg #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 160,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_count
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic              m_valid, m_valid_nxt;
    logic [CTRL_W-1:0] m_ctrl, m_ctrl_nxt;
    logic [DATA_W-1:0] m_data, m_data_nxt;
    logic              s_valid, s_valid_nxt;
    logic [CTRL_W-1:0] s_ctrl, s_ctrl_nxt;
    logic [DATA_W-1:0] s_data, s_data_nxt;
    logic              in_ready_q, in_ready_q_nxt;
    logic [CNT_W-1:0]  drop_cnt, drop_cnt_nxt;

    logic              accept;
    logic              pop;
    logic              m_free;
    logic [1:0]        drop_inc;
    logic [SUM_W-1:0]  drop_sum;

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = !m_valid || out_ready;
        end
    endgenerate

    assign accept = in_valid && in_ready;
    assign pop    = m_valid && out_ready;
    assign m_free = !m_valid || pop;

    // A popping M is owned downstream, so it is not a squashed entry.
    assign drop_inc = 2'(m_valid && !pop) + 2'(s_valid) + 2'(accept);
    assign drop_sum = {1'b0, drop_cnt} + SUM_W'(drop_inc);

    always_comb begin
        m_valid_nxt    = m_valid;
        m_ctrl_nxt     = m_ctrl;
        m_data_nxt     = m_data;
        s_valid_nxt    = s_valid;
        s_ctrl_nxt     = s_ctrl;
        s_data_nxt     = s_data;
        drop_cnt_nxt   = drop_cnt;

        if (flush) begin
            m_valid_nxt  = 1'b0;
            m_ctrl_nxt   = '0;
            m_data_nxt   = '0;
            s_valid_nxt  = 1'b0;
            s_ctrl_nxt   = '0;
            s_data_nxt   = '0;
            drop_cnt_nxt = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end else if (m_free) begin
            if (s_valid) begin
                // in_ready was low, so nothing is accepted this cycle.
                m_valid_nxt = 1'b1;
                m_ctrl_nxt  = s_ctrl;
                m_data_nxt  = s_data;
                s_valid_nxt = 1'b0;
            end else if (accept) begin
                m_valid_nxt = 1'b1;
                m_ctrl_nxt  = in_ctrl;
                m_data_nxt  = in_data;
            end else begin
                // Bubble: control cleared, data left as-is.
                m_valid_nxt = 1'b0;
                m_ctrl_nxt  = '0;
            end
        end else if (accept && (SKID != 0)) begin
            s_valid_nxt = 1'b1;
            s_ctrl_nxt  = in_ctrl;
            s_data_nxt  = in_data;
        end

        in_ready_q_nxt = !s_valid_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_ctrl     <= '0;
            m_data     <= '0;
            s_valid    <= 1'b0;
            s_ctrl     <= '0;
            s_data     <= '0;
            in_ready_q <= 1'b1;
            drop_cnt   <= '0;
        end else begin
            m_valid    <= m_valid_nxt;
            m_ctrl     <= m_ctrl_nxt;
            m_data     <= m_data_nxt;
            s_valid    <= s_valid_nxt;
            s_ctrl     <= s_ctrl_nxt;
            s_data     <= s_data_nxt;
            in_ready_q <= in_ready_q_nxt;
            drop_cnt   <= drop_cnt_nxt;
        end
    end

    assign out_valid  = m_valid;
    assign out_ctrl   = m_ctrl;
    assign out_data   = m_data;
    assign occupancy  = 2'(m_valid) + 2'(s_valid);
    assign drop_count = drop_cnt;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg
//   Directed bench for pipe_stage_skid_reg. u_skid uses SKID=1 with the default
//   16-bit counter; u_single uses SKID=0 with a 4-bit counter so saturation of
//   drop_count is reachable in a few cycles.
module tb_pipe_stage_skid_reg;

    logic         clk = 1'b0;
    logic         rst;

    logic         flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]   in_ctrl, out_ctrl;
    logic [159:0] in_data, out_data;
    logic [1:0]   occupancy;
    logic [15:0]  drop_count;

    logic         z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
    logic [7:0]   z_in_ctrl, z_out_ctrl;
    logic [159:0] z_in_data, z_out_data;
    logic [1:0]   z_occupancy;
    logic [3:0]   z_drop_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(.CTRL_W(8), .DATA_W(160), .SKID(1), .CNT_W(16)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .drop_count(drop_count)
    );

    pipe_stage_skid_reg #(.CTRL_W(8), .DATA_W(160), .SKID(0), .CNT_W(4)) u_single (
        .clk(clk), .rst(rst), .flush(z_flush),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_ctrl(z_in_ctrl), .in_data(z_in_data),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data),
        .occupancy(z_occupancy), .drop_count(z_drop_count)
    );

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] c, input logic [159:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ctrl = '0; in_data = '0;
        z_flush = 1'b0; z_in_valid = 1'b0; z_out_ready = 1'b0; z_in_ctrl = '0; z_in_data = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_valid", out_valid, 0);
        check("rst_ctrl", out_ctrl, 0);
        check("rst_data", out_data, 0);
        check("rst_occ", occupancy, 0);
        check("rst_drop", drop_count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_z_in_ready", z_in_ready, 1);

        // 1: streaming, one beat per cycle, one cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_ctrl = 8'(i);
            in_data = 160'(i);
            step();
            check("s1_valid", out_valid, 1);
            check("s1_data", out_data, 160'(i));
            check("s1_ctrl", out_ctrl, 8'(i));
            check("s1_occ", occupancy, 1);
            check("s1_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        check("s1_bubble_valid", out_valid, 0);
        check("s1_bubble_ctrl", out_ctrl, 0);
        check("s1_bubble_data_hold", out_data, 160'h8);
        check("s1_bubble_occ", occupancy, 0);

        // 2: skid fill and drain in order
        out_ready = 1'b0;
        push(8'h11, 160'hA);
        check("s2_occ1", occupancy, 1);
        check("s2_in_ready1", in_ready, 1);
        push(8'h22, 160'hB);
        check("s2_occ2", occupancy, 2);
        check("s2_in_ready0", in_ready, 0);
        check("s2_data_a", out_data, 160'hA);
        check("s2_ctrl_a", out_ctrl, 8'h11);
        out_ready = 1'b1;
        step();
        check("s2_data_b", out_data, 160'hB);
        check("s2_ctrl_b", out_ctrl, 8'h22);
        check("s2_valid_b", out_valid, 1);
        check("s2_in_ready_after_pop", in_ready, 1);
        check("s2_occ_after_pop", occupancy, 1);
        step();
        check("s2_drained", out_valid, 0);
        check("s2_drained_occ", occupancy, 0);

        // 3: flush with two held entries, then flush while empty
        out_ready = 1'b0;
        push(8'h33, 160'hC1);
        push(8'h44, 160'hC2);
        check("s3_occ2", occupancy, 2);
        flush = 1'b1;
        step();
        check("s3_valid", out_valid, 0);
        check("s3_ctrl", out_ctrl, 0);
        check("s3_data_zero", out_data, 0);
        check("s3_occ", occupancy, 0);
        check("s3_drop", drop_count, 2);
        check("s3_in_ready", in_ready, 1);
        step();
        check("s3_empty_flush_drop", drop_count, 2);
        flush = 1'b0;

        // 4: flush while M pops and a new beat is accepted
        push(8'h55, 160'hC3);
        check("s4_occ1", occupancy, 1);
        in_valid  = 1'b1;
        in_ctrl   = 8'h66;
        in_data   = 160'hD4;
        out_ready = 1'b1;
        flush     = 1'b1;
        check("s4_popping_data", out_data, 160'hC3);
        step();
        check("s4_drop", drop_count, 3);
        check("s4_valid", out_valid, 0);
        check("s4_occ", occupancy, 0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // 4b: flush with M held (no pop) and an accept into the skid slot
        push(8'h77, 160'hE5);
        in_valid = 1'b1;
        in_ctrl  = 8'h78;
        in_data  = 160'hE6;
        flush    = 1'b1;
        step();
        check("s4b_drop", drop_count, 5);
        check("s4b_occ", occupancy, 0);
        flush    = 1'b0;
        in_valid = 1'b0;

        // 5: reset overrides flush
        push(8'h81, 160'hF1);
        push(8'h82, 160'hF2);
        check("s5_occ2", occupancy, 2);
        rst   = 1'b1;
        flush = 1'b1;
        step();
        rst   = 1'b0;
        flush = 1'b0;
        check("s5_drop", drop_count, 0);
        check("s5_valid", out_valid, 0);
        check("s5_ctrl", out_ctrl, 0);
        check("s5_data", out_data, 0);
        check("s5_occ", occupancy, 0);
        check("s5_in_ready", in_ready, 1);

        // 6: single-entry mode, combinational in_ready and saturation
        z_out_ready = 1'b0;
        z_in_valid  = 1'b1;
        z_in_ctrl   = 8'h31;
        z_in_data   = 160'h31;
        step();
        check("s6_full_valid", z_out_valid, 1);
        check("s6_full_in_ready", z_in_ready, 0);
        check("s6_full_occ", z_occupancy, 1);
        z_in_ctrl   = 8'h32;
        z_in_data   = 160'h32;
        z_out_ready = 1'b1;
        #1;
        check("s6_comb_in_ready", z_in_ready, 1);
        step();
        check("s6_replace_valid", z_out_valid, 1);
        check("s6_replace_data", z_out_data, 160'h32);
        check("s6_replace_ctrl", z_out_ctrl, 8'h32);
        check("s6_replace_occ", z_occupancy, 1);

        z_flush = 1'b1;
        for (int i = 0; i < 14; i++) step();
        check("s6_drop14", z_drop_count, 4'hE);
        z_flush     = 1'b0;
        z_out_ready = 1'b0;
        step();
        check("s6_refill", z_out_valid, 1);
        z_flush = 1'b1;
        step();
        check("s6_drop15", z_drop_count, 4'hF);
        check("s6_flush_valid", z_out_valid, 0);
        step();
        check("s6_drop_sat", z_drop_count, 4'hF);
        z_flush    = 1'b0;
        z_in_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
